// File: rtl/beep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beep_pkg : FSM state encodings, source codes and priority pick helper.    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
package beep_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ON     = 2'd1,
      ST_OFF    = 2'd2,
      ST_SNOOZE = 2'd3
   } beep_state_t;

   localparam logic [1:0] SRC_NONE  = 2'd0;
   localparam logic [1:0] SRC_ALARM = 2'd1;
   localparam logic [1:0] SRC_TIMER = 2'd2;
   localparam logic [1:0] SRC_CHIME = 2'd3;

   // pend[0]=alarm, pend[1]=timer, pend[2]=chime; lower source code wins.
   function automatic logic [1:0] f_pick(input logic [2:0] pend);
      logic [1:0] w_src;
      w_src = SRC_NONE;
      if (pend[2]) w_src = SRC_CHIME;
      if (pend[1]) w_src = SRC_TIMER;
      if (pend[0]) w_src = SRC_ALARM;
      return w_src;
   endfunction

endpackage
`default_nettype wire

// File: rtl/beep_tone_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beep_tone_gen : square-wave tone, high on (re)start, low while disabled.   |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module beep_tone_gen #(
   parameter int TONE_DIV = 12500
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic en,
   input  logic restart,
   output logic tone
);

   localparam int            c_tw   = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
   localparam logic [c_tw-1:0] c_last = c_tw'(TONE_DIV - 1);

   logic [c_tw-1:0] r_tone_cnt;
   logic            r_tone;

   // en and restart describe the coming cycle, so tone is valid on the same
   // edge the controller enters its on phase.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tone_cnt <= '0;
         r_tone     <= 1'b0;
      end else if (!en) begin
         r_tone_cnt <= '0;
         r_tone     <= 1'b0;
      end else if (restart) begin
         r_tone_cnt <= '0;
         r_tone     <= 1'b1;
      end else if (r_tone_cnt == c_last) begin
         r_tone_cnt <= '0;
         r_tone     <= ~r_tone;
      end else begin
         r_tone_cnt <= r_tone_cnt + 1'b1;
      end
   end

   assign tone = r_tone;

endmodule
`default_nettype wire

// File: rtl/beep_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beep_arbiter : shares the buzzer between alarm, timer and chime events.    |
// | Optional snooze state/port enabled by macro BEEP_SNOOZE_EN. Revision 1.0  |
// +----------------------------------------------------------------------------+
module beep_arbiter
   import beep_pkg::*;
#(
   parameter int TONE_DIV    = 12500,
   parameter int ON_CYC      = 25000000,
   parameter int OFF_CYC     = 25000000,
   parameter int ALARM_BEEPS = 30,
   parameter int TIMER_BEEPS = 10,
   parameter int CHIME_BEEPS = 1,
   parameter int SNOOZE_CYC  = 1500000000
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       alarm_req,
   input  logic       timer_req,
   input  logic       chime_req,
   input  logic       cancel_pre,
`ifdef BEEP_SNOOZE_EN
   input  logic       snooze_pre,
`endif
   output logic       beep_out,
   output logic       busy,
   output logic [1:0] active_src
);

   localparam int c_ph_max = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int c_ph_w   = (c_ph_max > 1) ? $clog2(c_ph_max) : 1;
   localparam int c_b_ab   = (ALARM_BEEPS > TIMER_BEEPS) ? ALARM_BEEPS : TIMER_BEEPS;
   localparam int c_b_max  = (c_b_ab > CHIME_BEEPS) ? c_b_ab : CHIME_BEEPS;
   localparam int c_bc_w   = $clog2(c_b_max + 1);

   localparam logic [c_ph_w-1:0] c_on_last  = c_ph_w'(ON_CYC - 1);
   localparam logic [c_ph_w-1:0] c_off_last = c_ph_w'(OFF_CYC - 1);

   beep_state_t       r_state, w_state_nxt;
   logic [1:0]        r_src, w_src_nxt;
   logic [c_bc_w-1:0] r_beep, w_beep_nxt;
   logic [c_ph_w-1:0] r_ph, w_ph_nxt;
   logic [2:0]        r_pend, w_pend_nxt;
   logic [2:0]        w_req, w_mask, w_pend_all;
   logic [1:0]        w_pick, w_grant;
   logic              w_preempt, w_restart, w_tone, w_parked;

`ifdef BEEP_SNOOZE_EN
   localparam int                c_sn_w     = (SNOOZE_CYC > 1) ? $clog2(SNOOZE_CYC) : 1;
   localparam logic [c_sn_w-1:0] c_snz_last = c_sn_w'(SNOOZE_CYC - 1);

   logic [c_sn_w-1:0] r_snz, w_snz_nxt;
   logic              r_parked, w_parked_nxt;
   logic              w_snooze_go;

   assign w_parked    = r_parked;
   assign w_snooze_go = snooze_pre && (r_src == SRC_ALARM);
`else
   assign w_parked = 1'b0;
`endif

   function automatic logic [c_bc_w-1:0] f_beeps(input logic [1:0] src);
      case (src)
         SRC_ALARM: f_beeps = c_bc_w'(ALARM_BEEPS);
         SRC_TIMER: f_beeps = c_bc_w'(TIMER_BEEPS);
         SRC_CHIME: f_beeps = c_bc_w'(CHIME_BEEPS);
         default:   f_beeps = '0;
      endcase
   endfunction

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_src    <= SRC_NONE;
         r_beep   <= '0;
         r_ph     <= '0;
         r_pend   <= '0;
`ifdef BEEP_SNOOZE_EN
         r_snz    <= '0;
         r_parked <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_src    <= w_src_nxt;
         r_beep   <= w_beep_nxt;
         r_ph     <= w_ph_nxt;
         r_pend   <= w_pend_nxt;
`ifdef BEEP_SNOOZE_EN
         r_snz    <= w_snz_nxt;
         r_parked <= w_parked_nxt;
`endif
      end
   end

   always_comb begin
      // A parked (snoozed) alarm still counts as the alarm being in progress.
      w_req      = {chime_req, timer_req, alarm_req};
      w_mask     = {r_src == SRC_CHIME, r_src == SRC_TIMER, (r_src == SRC_ALARM) | w_parked};
      w_pend_all = (r_pend | w_req) & ~w_mask;
      w_pick     = f_pick(w_pend_all);
      w_preempt  = (w_pick != SRC_NONE) && (w_pick < r_src);

      w_state_nxt = r_state;
      w_src_nxt   = r_src;
      w_beep_nxt  = r_beep;
      w_ph_nxt    = r_ph + 1'b1;
      w_pend_nxt  = w_pend_all;
      w_grant     = SRC_NONE;
      w_restart   = 1'b0;
`ifdef BEEP_SNOOZE_EN
      w_snz_nxt    = r_snz;
      w_parked_nxt = r_parked;
`endif

      case (r_state)
         ST_IDLE: begin
            w_ph_nxt = '0;
            w_grant  = w_pick;
         end
         ST_ON: begin
`ifdef BEEP_SNOOZE_EN
            if (w_snooze_go) begin
               w_state_nxt  = ST_SNOOZE;
               w_ph_nxt     = '0;
               w_beep_nxt   = '0;
               w_snz_nxt    = '0;
               w_parked_nxt = 1'b1;
            end else
`endif
            if (w_preempt) begin
               w_grant = w_pick;
            end else if (r_ph == c_on_last) begin
               w_state_nxt = ST_OFF;
               w_ph_nxt    = '0;
            end
         end
         ST_OFF: begin
`ifdef BEEP_SNOOZE_EN
            if (w_snooze_go) begin
               w_state_nxt  = ST_SNOOZE;
               w_ph_nxt     = '0;
               w_beep_nxt   = '0;
               w_snz_nxt    = '0;
               w_parked_nxt = 1'b1;
            end else
`endif
            if (w_preempt) begin
               w_grant = w_pick;
            end else if (r_ph == c_off_last) begin
               w_ph_nxt = '0;
               if (r_beep > c_bc_w'(1)) begin
                  w_state_nxt = ST_ON;
                  w_beep_nxt  = r_beep - 1'b1;
                  w_restart   = 1'b1;
               end else if (w_pick != SRC_NONE) begin
                  w_grant = w_pick;
`ifdef BEEP_SNOOZE_EN
               end else if (r_parked) begin
                  w_state_nxt = ST_SNOOZE;
                  w_src_nxt   = SRC_ALARM;
                  w_beep_nxt  = '0;
`endif
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_src_nxt   = SRC_NONE;
                  w_beep_nxt  = '0;
               end
            end
         end
`ifdef BEEP_SNOOZE_EN
         ST_SNOOZE: begin
            w_ph_nxt = '0;
            if (w_pick != SRC_NONE) begin
               w_grant = w_pick;
            end else if (r_snz == c_snz_last) begin
               w_grant      = SRC_ALARM;
               w_parked_nxt = 1'b0;
               w_snz_nxt    = '0;
            end else begin
               w_snz_nxt = r_snz + 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
            w_src_nxt   = SRC_NONE;
            w_ph_nxt    = '0;
         end
      endcase

      if (w_grant != SRC_NONE) begin
         w_state_nxt                  = ST_ON;
         w_src_nxt                    = w_grant;
         w_beep_nxt                   = f_beeps(w_grant);
         w_ph_nxt                     = '0;
         w_restart                    = 1'b1;
         w_pend_nxt[w_grant - 2'd1]   = 1'b0;
      end

      if (cancel_pre) begin
         w_state_nxt  = ST_IDLE;
         w_src_nxt    = SRC_NONE;
         w_beep_nxt   = '0;
         w_ph_nxt     = '0;
         w_pend_nxt   = '0;
         w_restart    = 1'b0;
`ifdef BEEP_SNOOZE_EN
         w_snz_nxt    = '0;
         w_parked_nxt = 1'b0;
`endif
      end
   end

   beep_tone_gen #(
      .TONE_DIV (TONE_DIV)
   ) u_tone (
      .sys_clk (sys_clk),
      .rst_n   (rst_n),
      .en      (w_state_nxt == ST_ON),
      .restart (w_restart),
      .tone    (w_tone)
   );

   assign beep_out   = w_tone;
   assign busy       = (r_state != ST_IDLE);
   assign active_src = r_src;

endmodule
`default_nettype wire

// File: tb/tb_beep_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_beep_arbiter : directed + random stimulus against a timeline model.     |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_beep_arbiter;

   localparam int TONE_DIV    = 2;
   localparam int ON_CYC      = 8;
   localparam int OFF_CYC     = 4;
   localparam int ALARM_BEEPS = 3;
   localparam int TIMER_BEEPS = 2;
   localparam int CHIME_BEEPS = 1;
   localparam int SNOOZE_CYC  = 20;
   localparam int PERIOD      = ON_CYC + OFF_CYC;
`ifdef BEEP_SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif

   logic       sys_clk    = 1'b0;
   logic       rst_n      = 1'b0;
   logic       alarm_req  = 1'b0;
   logic       timer_req  = 1'b0;
   logic       chime_req  = 1'b0;
   logic       cancel_pre = 1'b0;
   logic       snooze_pre = 1'b0;
   logic       beep_out;
   logic       busy;
   logic [1:0] active_src;

   int n_pass  = 0;
   int n_total = 0;

   // Model: who is playing, cycles elapsed since the grant, pending set.
   int m_src = 0;
   int m_t   = 0;
   int m_snz = 0;
   bit m_in_snz = 1'b0;
   bit m_parked = 1'b0;
   bit m_pend [1:3];

   always #5 sys_clk = ~sys_clk;

   beep_arbiter #(
      .TONE_DIV    (TONE_DIV),
      .ON_CYC      (ON_CYC),
      .OFF_CYC     (OFF_CYC),
      .ALARM_BEEPS (ALARM_BEEPS),
      .TIMER_BEEPS (TIMER_BEEPS),
      .CHIME_BEEPS (CHIME_BEEPS),
      .SNOOZE_CYC  (SNOOZE_CYC)
   ) u_dut (
      .sys_clk    (sys_clk),
      .rst_n      (rst_n),
      .alarm_req  (alarm_req),
      .timer_req  (timer_req),
      .chime_req  (chime_req),
      .cancel_pre (cancel_pre),
`ifdef BEEP_SNOOZE_EN
      .snooze_pre (snooze_pre),
`endif
      .beep_out   (beep_out),
      .busy       (busy),
      .active_src (active_src)
   );

   function automatic int beeps_of(input int s);
      if (s == 1) return ALARM_BEEPS;
      if (s == 2) return TIMER_BEEPS;
      if (s == 3) return CHIME_BEEPS;
      return 0;
   endfunction

   function automatic int exp_beep();
      int w;
      if (m_src == 0 || m_in_snz) return 0;
      w = m_t % PERIOD;
      return ((w < ON_CYC) && ((w / TONE_DIV) % 2 == 0)) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_src = 0; m_t = 0; m_snz = 0; m_in_snz = 1'b0; m_parked = 1'b0;
      for (int i = 1; i <= 3; i++) m_pend[i] = 1'b0;
   endtask

   task automatic grant(input int g);
      m_src = g; m_t = 0; m_pend[g] = 1'b0; m_in_snz = 1'b0;
   endtask

   task automatic model_step(input bit a, input bit t, input bit c, input bit x, input bit s);
      bit req [1:3];
      int best;
      if (x) begin
         model_reset();
         return;
      end
      req[1] = a; req[2] = t; req[3] = c;
      for (int i = 1; i <= 3; i++)
         if (req[i] && i != m_src && !(i == 1 && m_parked)) m_pend[i] = 1'b1;
      best = 0;
      for (int i = 3; i >= 1; i--) if (m_pend[i]) best = i;
      if (m_src == 0) begin
         if (best != 0) grant(best);
      end else if (m_in_snz) begin
         if (best != 0) grant(best);
         else begin
            m_snz++;
            if (m_snz == SNOOZE_CYC) begin
               m_parked = 1'b0;
               m_snz    = 0;
               grant(1);
            end
         end
      end else if (SNZ && s && m_src == 1) begin
         m_in_snz = 1'b1; m_parked = 1'b1; m_snz = 0;
      end else if (best != 0 && best < m_src) begin
         grant(best);
      end else begin
         m_t++;
         if (m_t == beeps_of(m_src) * PERIOD) begin
            if (best != 0) grant(best);
            else if (m_parked) begin m_in_snz = 1'b1; m_src = 1; end
            else m_src = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic cycle(input bit a, input bit t, input bit c, input bit x, input bit s);
      alarm_req = a; timer_req = t; chime_req = c; cancel_pre = x; snooze_pre = s;
      @(posedge sys_clk);
      model_step(a, t, c, x, s);
      @(negedge sys_clk);
      alarm_req = 1'b0; timer_req = 1'b0; chime_req = 1'b0; cancel_pre = 1'b0; snooze_pre = 1'b0;
      chk("beep_out",   beep_out,   exp_beep());
      chk("busy",       busy,       (m_src != 0) ? 1 : 0);
      chk("active_src", active_src, m_src);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [11:0] pat;
      int          busy_n;
      bit          saw_timer;

      model_reset();
      repeat (2) @(negedge sys_clk);
      chk("rst_beep", beep_out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_src",  active_src, 0);
      rst_n = 1'b1;
      idle(2);

      // Chime alone: one beep, fixed waveform.
      pat = 12'b1100_1100_0000;
      cycle(0, 0, 1, 0, 0);
      chk("t1_busy", busy, 1);
      chk("t1_src", active_src, 3);
      chk("t1_wave", beep_out, pat[11]);
      for (int i = 1; i < 12; i++) begin
         cycle(0, 0, 0, 0, 0);
         chk("t1_wave", beep_out, pat[11 - i]);
      end
      cycle(0, 0, 0, 0, 0);
      chk("t1_done", busy, 0);
      idle(3);

      // Alarm and chime together: alarm first, chime follows.
      cycle(1, 0, 1, 0, 0);
      busy_n = 0;
      for (int i = 0; i < 70 && busy; i++) begin
         busy_n++;
         if (busy_n == 36) chk("t2_alarm_src", active_src, 1);
         if (busy_n == 37) chk("t2_chime_src", active_src, 3);
         cycle(0, 0, 0, 0, 0);
      end
      chk("t2_busy_len", busy_n, 48);
      idle(2);

      // Alarm preempts a running timer; timer never resumes.
      cycle(0, 1, 0, 0, 0);
      idle(4);
      cycle(1, 0, 0, 0, 0);
      chk("t3_src", active_src, 1);
      chk("t3_beep", beep_out, 1);
      busy_n = 0; saw_timer = 1'b0;
      for (int i = 0; i < 70 && busy; i++) begin
         busy_n++;
         if (active_src == 2'd2) saw_timer = 1'b1;
         cycle(0, 0, 0, 0, 0);
      end
      chk("t3_alarm_len", busy_n, 36);
      chk("t3_no_timer", saw_timer, 0);
      idle(2);

      // Cancel mid-alarm with a chime pending.
      cycle(1, 0, 0, 0, 0);
      idle(3);
      cycle(0, 0, 1, 0, 0);
      idle(5);
      cycle(0, 0, 0, 1, 0);
      chk("t4_beep", beep_out, 0);
      chk("t4_busy", busy, 0);
      chk("t4_src", active_src, 0);
      idle(20);
      chk("t4_no_chime", busy, 0);

      // Asynchronous reset in the middle of an on phase.
      cycle(0, 1, 0, 0, 0);
      idle(1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("t5_beep", beep_out, 0);
      chk("t5_busy", busy, 0);
      chk("t5_src", active_src, 0);
      @(negedge sys_clk);
      rst_n = 1'b1;
      idle(5);
      chk("t5_idle", busy, 0);

`ifdef BEEP_SNOOZE_EN
      // Snooze during the second alarm beep.
      cycle(1, 0, 0, 0, 0);
      idle(13);
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         if (i > 0) cycle(0, 0, 0, 0, 0);
         chk("t6_snz_beep", beep_out, 0);
         chk("t6_snz_busy", busy, 1);
      end
      cycle(0, 0, 0, 0, 0);
      chk("t6_resume_beep", beep_out, 1);
      chk("t6_resume_src", active_src, 1);
      busy_n = 0;
      for (int i = 0; i < 70 && busy; i++) begin
         busy_n++;
         cycle(0, 0, 0, 0, 0);
      end
      chk("t6_alarm_len", busy_n, 36);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 199) == 0,
               $urandom_range(0, 49) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
